// File: rtl/fifo_rx_pkg.sv
// rtl/fifo_rx_pkg.sv - shared state type, register map and timing defaults for fifo_rx
package fifo_rx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;

  localparam int CLK_DIV_DEFAULT      = 25;
  localparam int SAMPLE_POINT_DEFAULT = 12;

endpackage

// File: rtl/fifo_rx_sipo.sv
// rtl/fifo_rx_sipo.sv - serial-in parallel-out receiver: bit divider, bit index and shift register
module sipo
  import fifo_rx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLK_DIV      = CLK_DIV_DEFAULT,
  parameter int SAMPLE_POINT = SAMPLE_POINT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_din,
  output logic [WIDTH-1:0] o_byte,
  output logic             o_done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_SAMPLE = DW'(SAMPLE_POINT);
  localparam logic [IW-1:0] IDX_LAST   = IW'(WIDTH - 1);

  rx_state_e        r_state;
  rx_state_e        w_state_nxt;
  logic [DW-1:0]    r_div;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_sr;
  logic             r_done;
  logic             w_sample;

  assign w_sample = (r_state == SHIFT) && i_en && (r_div == DIV_SAMPLE);
  assign o_byte   = r_sr;
  assign o_done   = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_en)  w_state_nxt = SHIFT;
      SHIFT:   if (!i_en) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counters are held at zero outside SHIFT, so entering SHIFT always starts a fresh byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_idx  <= '0;
      r_sr   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_sample && (r_idx == IDX_LAST);
      if ((r_state != SHIFT) || !i_en) begin
        r_div <= '0;
        r_idx <= '0;
      end else begin
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        if (w_sample) begin
          r_sr[r_idx] <= i_din;
          r_idx       <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_rx.sv
// rtl/fifo_rx.sv - serial byte receiver feeding a FIFO drained over APB; FIFO_RX_STATUS_REG_EN adds STATUS/ovf
module fifo_rx
  import fifo_rx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 64,
  parameter int CLK_DIV      = CLK_DIV_DEFAULT,
  parameter int SAMPLE_POINT = SAMPLE_POINT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             en_IQ,
  input  logic [7:0]       paddr,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [7:0]       pwdata,
  output logic [WIDTH-1:0] prdata,
  output logic             pready,
  output logic             pslverr,
  output logic             mem_state,
  output logic             byte_valid
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] w_byte;
  logic             w_done;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_access;
  logic             w_rd_data;
  logic             w_rd_status;
  logic             w_unused;

  sipo #(
    .WIDTH        (WIDTH),
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_POINT (SAMPLE_POINT)
  ) u_sipo (
    .clk    (clk),
    .rst    (reset),
    .i_en   (en_IQ),
    .i_din  (data_in),
    .o_byte (w_byte),
    .o_done (w_done)
  );

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_push    = w_done && !w_full;
  assign w_access  = !reset && psel && penable;
  assign w_rd_data = w_access && !pwrite && (paddr == ADDR_DATA);
  assign w_pop     = w_rd_data && !w_empty;
  assign w_unused  = ^pwdata;

  assign pready     = 1'b1;
  assign mem_state  = !w_empty;
  assign byte_valid = w_push;

`ifdef FIFO_RX_STATUS_REG_EN
  logic r_ovf;

  assign w_rd_status = w_access && !pwrite && (paddr == ADDR_STATUS);

  // A drop in the same cycle as the clearing read keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_ovf <= 1'b0;
    else if (w_done && w_full) r_ovf <= 1'b1;
    else if (w_rd_status)     r_ovf <= 1'b0;
  end
`else
  assign w_rd_status = 1'b0;
`endif

  always_comb begin
    prdata = '0;
    if (w_pop) prdata = r_mem[r_rd_ptr[AW-1:0]];
`ifdef FIFO_RX_STATUS_REG_EN
    else if (w_rd_status) prdata = {r_ovf, w_full, w_empty, {(WIDTH-3){1'b0}}};
`endif
  end

  assign pslverr = w_access && !(w_pop || w_rd_status);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_byte;
  end

endmodule
